// File: rtl/nes_scaler.sv
// rtl/nes_scaler.sv - cropped NES framebuffer to centred HDMI window scaler, 3-clk latency
module nes_scaler #(
    parameter int SRC_W    = 256,
    parameter int SRC_H    = 240,
    parameter int CROP_TOP = 8,
    parameter int CROP_BOT = 8,
    parameter int DST_W    = 1280,
    parameter int DST_H    = 720,
    parameter int WIN_W_43 = 960,
    parameter int WIN_W_87 = 940,
    parameter int PIX_BITS = 6,
    parameter int ABITS    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [10:0]         cx,
    input  logic [9:0]          cy,
    input  logic                aspect_8x7,
    input  logic                overlay,
    input  logic [14:0]         overlay_color,
    input  logic [23:0]         border_rgb,
    output logic [ABITS-1:0]    fb_addr,
    input  logic [PIX_BITS-1:0] fb_rdata,
    output logic [7:0]          overlay_x,
    output logic [7:0]          overlay_y,
    output logic [23:0]         rgb,
    output logic                active_out
);
    localparam int VIS_H = SRC_H - CROP_TOP - CROP_BOT;
    localparam int XW    = $clog2(DST_W) + 1;
    localparam int YW    = $clog2(DST_H) + 1;

    localparam logic [23:0] PALETTE [64] = '{
        24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
        24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
        24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
        24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
        24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
        24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
        24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
        24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
    };

    logic [XW-1:0] r_win_w;
    logic [XW-1:0] r_xcnt;
    logic [YW-1:0] r_ycnt;
    logic [7:0]    r_xx;
    logic [7:0]    r_yy;
    logic          r_active_d1;
    logic          r_active_d2;

    logic          w_frame_start;
    logic [XW-1:0] w_win_w;
    logic [XW-1:0] w_xstart;
    logic [XW-1:0] w_xend;
    logic          w_in_win;
    logic [XW-1:0] w_xsum;
    logic [YW-1:0] w_ysum;
    logic [XW-1:0] w_xcnt_n;
    logic [YW-1:0] w_ycnt_n;
    logic [7:0]    w_xx_n;
    logic [7:0]    w_yy_n;

    // Aspect is only taken at the frame origin so a frame never mixes window widths.
    assign w_frame_start = (cx == '0) && (cy == '0);
    assign w_win_w  = w_frame_start ? (aspect_8x7 ? XW'(WIN_W_87) : XW'(WIN_W_43)) : r_win_w;
    assign w_xstart = (XW'(DST_W) - w_win_w) >> 1;
    assign w_xend   = w_xstart + w_win_w;
    assign w_in_win = (XW'(cx) >= w_xstart) && (XW'(cx) < w_xend) && (YW'(cy) < YW'(DST_H));

    assign w_xsum = r_xcnt + XW'(SRC_W);
    assign w_ysum = r_ycnt + YW'(VIS_H);

    // r_xx holds the source column of the previous raster pixel; step it once per in-window pixel.
    always_comb begin
        w_xx_n   = r_xx;
        w_xcnt_n = r_xcnt;
        if (cx == '0) begin
            w_xx_n   = '0;
            w_xcnt_n = '0;
        end else if (r_active_d1) begin
            if (w_xsum >= r_win_w) begin
                w_xcnt_n = w_xsum - r_win_w;
                if (r_xx != 8'(SRC_W - 1))
                    w_xx_n = r_xx + 8'd1;
            end else begin
                w_xcnt_n = w_xsum;
            end
        end
    end

    always_comb begin
        w_yy_n   = r_yy;
        w_ycnt_n = r_ycnt;
        if (cy == '0) begin
            w_yy_n   = '0;
            w_ycnt_n = '0;
        end else if ((cx == '0) && (YW'(cy) < YW'(DST_H))) begin
            if (w_ysum >= YW'(DST_H)) begin
                w_ycnt_n = w_ysum - YW'(DST_H);
                if (r_yy != 8'(VIS_H - 1))
                    w_yy_n = r_yy + 8'd1;
            end else begin
                w_ycnt_n = w_ysum;
            end
        end
    end

    assign fb_addr   = ABITS'((32'(r_yy) + CROP_TOP) * SRC_W + 32'(r_xx));
    assign overlay_x = r_xx;
    assign overlay_y = r_yy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_win_w     <= XW'(WIN_W_43);
            r_xx        <= '0;
            r_yy        <= '0;
            r_xcnt      <= '0;
            r_ycnt      <= '0;
            r_active_d1 <= 1'b0;
            r_active_d2 <= 1'b0;
            rgb         <= 24'h0;
            active_out  <= 1'b0;
        end else begin
            r_win_w     <= w_win_w;
            r_xx        <= w_xx_n;
            r_yy        <= w_yy_n;
            r_xcnt      <= w_xcnt_n;
            r_ycnt      <= w_ycnt_n;
            r_active_d1 <= w_in_win;
            r_active_d2 <= r_active_d1;
            active_out  <= r_active_d2;
            if (!r_active_d2)
                rgb <= border_rgb;
            else if (overlay)
                rgb <= {overlay_color[4:0], 3'b000, overlay_color[9:5], 3'b000,
                        overlay_color[14:10], 3'b000};
            else
                rgb <= PALETTE[fb_rdata];
        end
    end
endmodule

// File: tb/tb_nes_scaler.sv
// tb/tb_nes_scaler.sv - scoreboard bench for nes_scaler
module tb_nes_scaler;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic        aspect_8x7 = 1'b0;
    logic        overlay = 1'b0;
    logic [14:0] overlay_color = '0;
    logic [23:0] border_rgb = 24'h102030;
    logic [15:0] fb_addr;
    logic [5:0]  fb_rdata = '0;
    logic [7:0]  overlay_x;
    logic [7:0]  overlay_y;
    logic [23:0] rgb;
    logic        active_out;

    nes_scaler dut (
        .clk(clk), .resetn(resetn), .cx(cx), .cy(cy), .aspect_8x7(aspect_8x7),
        .overlay(overlay), .overlay_color(overlay_color), .border_rgb(border_rgb),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata), .overlay_x(overlay_x),
        .overlay_y(overlay_y), .rgb(rgb), .active_out(active_out)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] PAL [64] = '{
        24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
        24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
        24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
        24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
        24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
        24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
        24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
        24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
    };

    typedef struct {
        logic [23:0] rgb;
        logic        act;
    } pix_t;

    pix_t        qp[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          m_win = 960;
    logic        fb_const_en = 1'b0;
    logic [5:0]  fb_const = '0;
    logic        oc_const_en = 1'b0;
    logic [14:0] oc_const = '0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_ox = '0;
    logic [7:0]  last_oy = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] fb_fn(input logic [15:0] a);
        if (fb_const_en)
            return fb_const;
        return a[5:0] ^ a[11:6] ^ {2'b00, a[15:12]};
    endfunction

    function automatic logic [14:0] oc_fn(input logic [7:0] x, input logic [7:0] y);
        if (oc_const_en)
            return oc_const;
        return {y[4:0], x[7:3], x[4:0]};
    endfunction

    function automatic logic [23:0] bgr5_to_rgb(input logic [14:0] c);
        return {c[4:0], 3'b000, c[9:5], 3'b000, c[14:10], 3'b000};
    endfunction

    // One pixel clock; push=0 clocks without new expectations so the pipeline drains.
    task automatic cyc(input int x, input int y, input bit push);
        int   xs, exx, eyy, eaddr;
        logic inw;
        pix_t e;
        cx = 11'(x);
        cy = 10'(y);
        inw = 1'b0; exx = 0; eyy = 0; eaddr = 0;
        if (push) begin
            if (x == 0 && y == 0)
                m_win = aspect_8x7 ? 940 : 960;
            xs  = (1280 - m_win) / 2;
            inw = (x >= xs) && (x < xs + m_win) && (y < 720);
            exx = inw ? (256 * (x - xs)) / m_win : 0;
            eyy = (224 * y) / 720;
            if (eyy > 223)
                eyy = 223;
            eaddr = (eyy + 8) * 256 + exx;
            e.act = inw;
            if (!inw)
                e.rgb = border_rgb;
            else if (overlay)
                e.rgb = bgr5_to_rgb(oc_fn(8'(exx), 8'(eyy)));
            else
                e.rgb = PAL[fb_fn(16'(eaddr))];
            qp.push_back(e);
        end
        @(posedge clk);
        #1;
        fb_rdata      = fb_fn(last_addr);
        overlay_color = oc_fn(last_ox, last_oy);
        last_addr = fb_addr;
        last_ox   = overlay_x;
        last_oy   = overlay_y;
        if (push && inw) begin
            check("addr", 32'(fb_addr), 32'(eaddr));
            check("ovx", 32'(overlay_x), 32'(exx));
            check("ovy", 32'(overlay_y), 32'(eyy));
        end
        if (push) begin
            if (y == 0 && x == 160 && m_win == 960) check("addr_cx160", 32'(fb_addr), 32'd2048);
            if (y == 0 && x == 175 && m_win == 960) check("xx_cx175", 32'(overlay_x), 32'd4);
            if (y == 0 && x == 1119 && m_win == 960) check("addr_cx1119", 32'(fb_addr), 32'd2303);
            if (y == 719 && x == 1119) check("addr_line719", 32'(fb_addr), 32'd59391);
            if (y == 3 && x == 0) check("yy_line3", 32'(overlay_y), 32'd0);
            if (y == 4 && x == 0) check("yy_line4", 32'(overlay_y), 32'd1);
            if (y == 0 && x == 1109 && m_win == 940) check("xx_87_cx1109", 32'(overlay_x), 32'd255);
            if (overlay_y > 8'd223) check("yy_max", 32'(overlay_y), 32'd223);
        end
        if (qp.size() >= 3 || (!push && qp.size() > 0)) begin
            e = qp.pop_front();
            check("rgb", 32'(rgb), 32'(e.rgb));
            check("active", 32'(active_out), 32'(e.act));
        end
    endtask

    task automatic row(input int y, input int n);
        for (int x = 0; x < n; x++)
            cyc(x, y, 1'b1);
    endtask

    task automatic drain();
        repeat (2) cyc(1280, 0, 1'b0);
    endtask

    initial begin
        // Reset held with the raster running.
        for (int i = 0; i < 4; i++) begin
            cx = 11'(200 + i);
            @(posedge clk);
            #1;
            check("rst_rgb", 32'(rgb), 32'd0);
            check("rst_active", 32'(active_out), 32'd0);
        end
        resetn = 1'b1;

        // Frame 1: 4:3, full rows at lines 0, 4 and 719.
        row(0, 1280);
        for (int y = 1; y < 719; y++)
            row(y, (y == 4) ? 1280 : 4);
        row(719, 1280);

        // Frame 2: mid-frame aspect request is ignored until the next frame.
        for (int y = 0; y < 100; y++)
            row(y, 4);
        aspect_8x7 = 1'b1;
        row(100, 1280);
        row(0, 1280);
        aspect_8x7 = 1'b0;

        // Hashed overlay against a grey border, then reset mid-line.
        drain();
        overlay = 1'b1;
        border_rgb = 24'h303030;
        row(0, 1280);
        row(1, 400);
        resetn = 1'b0;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'd0);
        check("async_rst_active", 32'(active_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cx = 11'(400 + i);
            @(posedge clk);
            #1;
            check("rst_mid_rgb", 32'(rgb), 32'd0);
            check("rst_mid_active", 32'(active_out), 32'd0);
        end
        qp.delete();
        m_win = 960;
        resetn = 1'b1;

        // Overlay priority over palette index 0.
        oc_const_en = 1'b1;
        oc_const = 15'h7C1F;
        fb_const_en = 1'b1;
        fb_const = 6'h00;
        row(0, 1280);
        drain();
        overlay = 1'b0;
        row(0, 1280);
        drain();
        fb_const = 6'h20;
        row(0, 1280);
        drain();
        fb_const_en = 1'b0;
        border_rgb = 24'hA5C3E1;
        row(0, 1280);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
